cpu_instr_sequencer: RTL and testbench

//  Program sequencer that feeds the 20-bit instruction input of simple_cpu.

---
 rtl/cpu_instr_sequencer.sv | 107 ++++++++++
 tb/tb_cpu_instr_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: issues a stored program to simple_cpu, each word held HOLD_CYCLES clocks
module cpu_instr_sequencer #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_wdata,
  input  logic [PC_BITS:0]       prog_len,
  input  logic                   start,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic                   prog_err
);
  localparam int DEPTH = 2 ** PC_BITS;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [PC_BITS:0] DEPTH_LEN = (PC_BITS + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [INSTR_WIDTH-1:0] store [DEPTH];
  logic [INSTR_WIDTH-1:0] instruction_n, first_word;
  logic [PC_BITS-1:0] pc_n;
  logic [PC_BITS:0] len, len_n, len_clamp;
  logic [HW-1:0] hold, hold_n;
  logic busy_n, done_n, err_n, wr;
  assign wr = prog_we && state != RUN;
  // a write landing on the start edge must be seen by the first fetch
  assign first_word = (wr && prog_addr == '0) ? prog_wdata : store[0];
  assign len_clamp = prog_len > DEPTH_LEN ? DEPTH_LEN : prog_len;
  always_ff @(posedge clk)
    if (wr) store[prog_addr] <= prog_wdata;
  always_comb begin
    state_n = state;
    instruction_n = instruction;
    pc_n = pc;
    hold_n = hold;
    len_n = len;
    busy_n = busy;
    done_n = 1'b0;
    err_n = prog_we && state == RUN;
    case (state)
      IDLE: if (start && !abort) begin
        len_n = len_clamp;
        if (len_clamp == '0) begin
          state_n = DONE;
          done_n = 1'b1;
        end else begin
          state_n = RUN;
          pc_n = '0;
          instruction_n = first_word;
          hold_n = HOLD_INIT;
          busy_n = 1'b1;
        end
      end
      RUN: if (abort) begin
        state_n = IDLE;
        instruction_n = '0;
        busy_n = 1'b0;
        pc_n = '0;
        hold_n = '0;
      end else if (hold != '0) begin
        hold_n = hold - 1'b1;
      end else if ({1'b0, pc} == len - 1'b1) begin
        state_n = DONE;
        instruction_n = '0;
        busy_n = 1'b0;
        done_n = 1'b1;
      end else begin
        pc_n = pc + 1'b1;
        instruction_n = store[pc + 1'b1];
        hold_n = HOLD_INIT;
      end
      DONE: begin
        state_n = IDLE;
        pc_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      instruction <= '0;
      pc <= '0;
      hold <= '0;
      len <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      state <= state_n;
      instruction <= instruction_n;
      pc <= pc_n;
      hold <= hold_n;
      len <= len_n;
      busy <= busy_n;
      done <= done_n;
      prog_err <= err_n;
    end
endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb_cpu_instr_sequencer: directed and random checks against a cycle-count reference model
module tb_cpu_instr_sequencer;
  localparam int HOLD = 4;
  logic clk = 0, rst = 1, prog_we = 0, start = 0, abort = 0;
  logic [3:0] prog_addr = 0;
  logic [19:0] prog_wdata = 0;
  logic [4:0] prog_len = 0;
  logic [19:0] instruction;
  logic [3:0] pc;
  logic busy, done, prog_err;
  int total = 0, bad = 0;
  logic [19:0] mem [16];
  int ms = 0, k = 0, mlen = 0;
  logic e_done = 0, e_err = 0;
  cpu_instr_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .abort(abort),
    .instruction(instruction), .pc(pc), .busy(busy), .done(done), .prog_err(prog_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // ms: 0 idle, 1 running (k edges since start), 2 done cycle
  task automatic check_all();
    chk("instruction", 32'(instruction), ms == 1 ? 32'(mem[k / HOLD]) : 32'd0);
    chk("pc", 32'(pc), ms == 1 ? 32'(k / HOLD) : (ms == 2 && mlen > 0) ? 32'(mlen - 1) : 32'd0);
    chk("busy", 32'(busy), 32'(ms == 1));
    chk("done", 32'(done), 32'(e_done));
    chk("prog_err", 32'(prog_err), 32'(e_err));
  endtask
  task automatic model_edge();
    e_err = prog_we && ms == 1;
    if (prog_we && ms != 1) mem[prog_addr] = prog_wdata;
    e_done = 0;
    if (ms == 0) begin
      if (start && !abort) begin
        mlen = prog_len > 16 ? 16 : int'(prog_len);
        k = 0;
        if (mlen == 0) begin ms = 2; e_done = 1; end
        else ms = 1;
      end
    end else if (ms == 1) begin
      if (abort) ms = 0;
      else begin
        k++;
        if (k == HOLD * mlen) begin ms = 2; e_done = 1; end
      end
    end else ms = 0;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic wr(input logic [3:0] a, input logic [19:0] d);
    prog_we = 1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 0;
  endtask
  task automatic go(input logic [4:0] l);
    prog_len = l; start = 1;
    step();
    start = 0;
  endtask
  task automatic finish_run();
    for (int i = 0; i < 200 && ms != 0; i++) step();
    chk("run_terminated", 32'(ms), 32'd0);
  endtask
  initial begin
    #3;
    chk("rst_instruction", 32'(instruction), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(prog_err), 32'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) wr(4'(i), 20'($urandom));
    wr(0, 20'b01000111000000000000);
    wr(1, 20'b01010011000000000000);
    wr(2, 20'b01110010000000000001);
    go(3);
    finish_run();
    wr(0, 20'b11011000000011110000);
    wr(1, 20'b10111000000011110000);
    go(2);
    finish_run();
    go(0);
    step();
    go(17);
    finish_run();
    go(3);
    for (int i = 0; i < 5; i++) step();
    abort = 1;
    step();
    abort = 0;
    step();
    go(3);
    finish_run();
    prog_len = 3; start = 1;
    for (int i = 0; i < 40 && !(ms == 0 && !start); i++) begin
      prog_we = (ms == 1 && k == 3); prog_addr = 1; prog_wdata = 20'($urandom);
      step();
      if (ms == 2) start = 0;
    end
    prog_we = 0;
    go(3);
    finish_run();
    prog_we = 1; prog_addr = 0; prog_wdata = 20'($urandom);
    go(1);
    prog_we = 0;
    finish_run();
    go(5);
    repeat (6) step();
    #2 rst = 1;
    ms = 0; e_done = 0; e_err = 0;
    #1;
    chk("async_instruction", 32'(instruction), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(3) == 0);
      abort = ($urandom_range(19) == 0);
      prog_we = ($urandom_range(3) == 0);
      prog_addr = 4'($urandom);
      prog_wdata = 20'($urandom);
      prog_len = 5'($urandom_range(20));
      step();
    end
    start = 0; abort = 0; prog_we = 0;
    finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
